// File: rtl/data_route_pkg.sv
// Shared definitions for the data_route width converters.
package data_route_pkg;

    localparam int unsigned LANE_W_DEF = 64;

    // Replication codes: output repeats each distinct lane 1x, 2x or 4x.
    localparam logic [1:0] REP_NONE = 2'd0;
    localparam logic [1:0] REP_X2   = 2'd1;
    localparam logic [1:0] REP_X4   = 2'd2;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_route_w2n_rep_if.sv
// Wide-in / narrow-out AXI-Stream bundle for the data_route converter.
interface data_route_w2n_rep_if #(
    parameter int unsigned IN_W  = 1536,
    parameter int unsigned OUT_W = 256
);
    logic [IN_W-1:0]  s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [OUT_W-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tready;

    // Converter side: consumes the wide stream, produces the narrow one.
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    // Environment side: sources the wide stream, sinks the narrow one.
    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/data_route_lane_rep.sv
// Combinational replicate-and-mask: spreads the low `step` lanes across the
// whole output beat and zeroes lanes beyond the remaining valid count.
module data_route_lane_rep
    import data_route_pkg::*;
#(
    parameter int unsigned OUT_W  = 256,
    parameter int unsigned LANE_W = LANE_W_DEF,
    parameter int unsigned CW     = 6
) (
    input  logic [OUT_W-1:0] i_lanes,
    input  logic [CW-1:0]    i_step,
    input  logic [CW-1:0]    i_lanes_left,
    output logic [OUT_W-1:0] o_tdata
);
    localparam int unsigned NL = OUT_W / LANE_W;

    logic [CW-1:0] w_src;

    // Output lane j takes source lane (j mod step); step is a power of two.
    always_comb begin
        o_tdata = '0;
        w_src   = '0;
        for (int unsigned j = 0; j < NL; j++) begin
            w_src = CW'(j) & (i_step - CW'(1));
            if (w_src < i_lanes_left) begin
                o_tdata[j*LANE_W +: LANE_W] = i_lanes[32'(w_src)*LANE_W +: LANE_W];
            end
        end
    end
endmodule

// File: rtl/data_route_w2n_rep.sv
// Wide-to-narrow AXI-Stream converter with lane replication. One input word
// is held and shifted out `step` lanes per beat, tlast on the final beat.
module data_route_w2n_rep
    import data_route_pkg::*;
#(
    parameter int unsigned IN_W   = 1536,
    parameter int unsigned OUT_W  = 256,
    parameter int unsigned LANE_W = LANE_W_DEF,
    parameter int unsigned IL_W   = 5,
    parameter int unsigned RL_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RL_W-1:0]    cfg_rep_log2,
    input  logic [IL_W:0]      cfg_in_lanes,
    data_route_w2n_rep_if.slave bus
);
    localparam int unsigned NL       = OUT_W / LANE_W;
    localparam int unsigned IN_LANES = IN_W / LANE_W;
    localparam int unsigned NL_LOG2  = clog2(NL);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    if (IN_W % LANE_W != 0) begin : g_chk_in_w
        $error("data_route_w2n_rep: IN_W must be a multiple of LANE_W");
    end
    if (OUT_W % LANE_W != 0) begin : g_chk_out_w
        $error("data_route_w2n_rep: OUT_W must be a multiple of LANE_W");
    end
    if (NL == 0 || (NL & (NL - 1)) != 0) begin : g_chk_nl
        $error("data_route_w2n_rep: OUT_W/LANE_W must be a power of two");
    end

    logic [0:0]      r_state;
    logic [IN_W-1:0] r_hreg;
    logic [IL_W:0]   r_lanes_left;
    logic [IL_W:0]   r_step;

    logic            w_busy;
    logic            w_tlast;
    logic            w_out_hs;
    logic            w_s_ready;
    logic            w_accept;
    logic [RL_W-1:0] w_rep;
    logic [IL_W:0]   w_step_new;
    logic [IL_W:0]   w_lanes_new;
    logic [31:0]     w_shamt;

    // Handshake terms; s_axis_tready only looks through m_axis_tready on the last beat.
    always_comb begin
        w_busy    = (r_state == ST_BUSY);
        w_tlast   = w_busy & (r_lanes_left <= r_step);
        w_out_hs  = w_busy & bus.m_axis_tready;
        w_s_ready = ~rst & (~w_busy | (w_out_hs & w_tlast));
        w_accept  = bus.s_axis_tvalid & w_s_ready;
        w_shamt   = 32'(r_step) * 32'(LANE_W);
    end

    // Config decode at accept: clamp replication code, default the lane count.
    always_comb begin
        w_rep       = (cfg_rep_log2 > RL_W'(NL_LOG2)) ? RL_W'(NL_LOG2) : cfg_rep_log2;
        w_step_new  = (IL_W+1)'(NL >> w_rep);
        w_lanes_new = (cfg_in_lanes == '0 || cfg_in_lanes > (IL_W+1)'(IN_LANES))
                    ? (IL_W+1)'(IN_LANES) : cfg_in_lanes;
    end

    // IDLE/BUSY FSM, holding register shifter and remaining-lane counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hreg       <= '0;
            r_lanes_left <= '0;
            r_step       <= '0;
        end else if (w_accept) begin
            r_state      <= ST_BUSY;
            r_hreg       <= bus.s_axis_tdata;
            r_lanes_left <= w_lanes_new;
            r_step       <= w_step_new;
        end else if (w_out_hs) begin
            if (w_tlast) begin
                r_state      <= ST_IDLE;
                r_lanes_left <= '0;
            end else begin
                r_hreg       <= r_hreg >> w_shamt;
                r_lanes_left <= r_lanes_left - r_step;
            end
        end
    end

    data_route_lane_rep #(
        .OUT_W  (OUT_W),
        .LANE_W (LANE_W),
        .CW     (IL_W + 1)
    ) u_lane_rep (
        .i_lanes      (r_hreg[OUT_W-1:0]),
        .i_step       (r_step),
        .i_lanes_left (r_lanes_left),
        .o_tdata      (bus.m_axis_tdata)
    );

    assign bus.s_axis_tready = w_s_ready;
    assign bus.m_axis_tvalid = w_busy;
    assign bus.m_axis_tlast  = w_tlast;

endmodule

// File: tb/tb_data_route_w2n_rep.sv
// Scoreboard bench for data_route_w2n_rep at default parameters.
module tb_data_route_w2n_rep;
    import data_route_pkg::*;

    localparam int unsigned IN_W     = 1536;
    localparam int unsigned OUT_W    = 256;
    localparam int unsigned LANE_W   = 64;
    localparam int unsigned IL_W     = 5;
    localparam int unsigned RL_W     = 2;
    localparam int unsigned NL       = 4;
    localparam int unsigned IN_LANES = 24;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [RL_W-1:0] cfg_rep_log2 = '0;
    logic [IL_W:0]   cfg_in_lanes = '0;
    logic            rand_ready = 1'b0;

    beat_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    hs_cnt = 0;
    int    cyc = 0;
    int    last_hs_cyc = 0;

    data_route_w2n_rep_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus();

    data_route_w2n_rep #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .LANE_W (LANE_W),
        .IL_W   (IL_W),
        .RL_W   (RL_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_rep_log2 (cfg_rep_log2),
        .cfg_in_lanes (cfg_in_lanes),
        .bus          (bus.slave)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [IN_W-1:0] mk_word(input logic [63:0] base);
        logic [IN_W-1:0] w;
        w = '0;
        for (int k = 0; k < int'(IN_LANES); k++) w[k*LANE_W +: LANE_W] = base + 64'(k);
        return w;
    endfunction

    // Expected beats: beat b, output lane j carries source lane b*step + (j%step).
    task automatic push_model(input logic [63:0] base, input int lanes, input int step);
        beat_t e;
        int nb;
        nb = (lanes + step - 1) / step;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            for (int j = 0; j < int'(NL); j++) begin
                int src;
                src = b * step + (j % step);
                if (src < lanes) e.data[j*LANE_W +: LANE_W] = base + 64'(src);
            end
            e.last = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_lit(input logic [OUT_W-1:0] d, input logic l);
        beat_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Present a word and return once it has been accepted; acc_cyc marks the accept edge.
    task automatic send(input logic [63:0] base, input logic [RL_W-1:0] r, input logic [IL_W:0] lanes_cfg,
                        input int exp_lanes, input int exp_step, input bit use_model, output int acc_cyc);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.s_axis_tdata  = mk_word(base);
        bus.s_axis_tvalid = 1'b1;
        cfg_rep_log2      = r;
        cfg_in_lanes      = lanes_cfg;
        #1;
        while (!bus.s_axis_tready && guard < 500) begin
            @(negedge clk);
            #1;
            guard++;
        end
        acc_cyc = cyc;
        if (!bus.s_axis_tready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: s_axis_tready=0 after %0d cycles, required 1", guard);
            bus.s_axis_tvalid = 1'b0;
        end else begin
            @(posedge clk);
            if (use_model) push_model(base, exp_lanes, exp_step);
        end
    endtask

    // Idle input with cfg scrambled; the converter must ignore it.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.s_axis_tvalid = 1'b0;
            cfg_rep_log2      = RL_W'($urandom);
            cfg_in_lanes      = (IL_W+1)'($urandom);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Ready source: constant 1 or random 50%.
    initial begin
        bus.m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            bus.m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks stall stability.
    initial begin
        beat_t            e;
        logic [OUT_W-1:0] p_data;
        logic             p_last;
        bit               p_stall;
        p_stall = 1'b0;
        p_data  = '0;
        p_last  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                p_stall = 1'b0;
            end else begin
                if (p_stall) begin
                    check("stall_tvalid", OUT_W'(bus.m_axis_tvalid), OUT_W'(1'b1));
                    check("stall_tdata", bus.m_axis_tdata, p_data);
                    check("stall_tlast", OUT_W'(bus.m_axis_tlast), OUT_W'(p_last));
                end
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_beat: got tdata %h, required no beat", bus.m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_tdata", bus.m_axis_tdata, e.data);
                        check("beat_tlast", OUT_W'(bus.m_axis_tlast), OUT_W'(e.last));
                    end
                    hs_cnt++;
                    last_hs_cyc = cyc;
                end
                p_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
                p_data  = bus.m_axis_tdata;
                p_last  = bus.m_axis_tlast;
            end
        end
    end

    initial begin
        int acc0;
        int acc1;
        int hs0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_tvalid", OUT_W'(bus.m_axis_tvalid), '0);
        check("rst_tlast", OUT_W'(bus.m_axis_tlast), '0);
        check("rst_tdata", bus.m_axis_tdata, '0);
        check("rst_s_tready", OUT_W'(bus.s_axis_tready), '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_s_tready", OUT_W'(bus.s_axis_tready), OUT_W'(1'b1));

        // r=0, 24 lanes: 6 beats of 4 distinct lanes, one per cycle
        send(64'h0, REP_NONE, 6'd24, 24, 4, 1'b1, acc0);
        idle(1);
        drain();
        check("r0_beat_cycles", OUT_W'(last_hs_cyc - acc0), OUT_W'(6));

        // r=2, 24 lanes: 24 beats of one lane replicated 4x
        send(64'h0, REP_X4, 6'd24, 24, 1, 1'b1, acc0);
        idle(1);
        drain();
        check("r2_beat_cycles", OUT_W'(last_hs_cyc - acc0), OUT_W'(24));

        // r=1, 5 lanes: hand-written beats, last one partial
        send(64'h0, REP_X2, 6'd5, 5, 2, 1'b0, acc0);
        push_lit({64'h1, 64'h0, 64'h1, 64'h0}, 1'b0);
        push_lit({64'h3, 64'h2, 64'h3, 64'h2}, 1'b0);
        push_lit({64'h0, 64'h4, 64'h0, 64'h4}, 1'b1);
        idle(1);
        drain();

        // Clamped code and defaulted lane counts
        send(64'h40, 2'd3, 6'd0, 24, 1, 1'b1, acc0);
        idle(1);
        drain();
        send(64'h60, REP_NONE, 6'd30, 24, 4, 1'b1, acc0);
        idle(1);
        drain();

        // Back-to-back words, no bubble; cfg scrambled once word 2 is in flight
        send(64'h100, REP_NONE, 6'd24, 24, 4, 1'b1, acc0);
        send(64'h200, REP_X4, 6'd24, 24, 1, 1'b1, acc1);
        check("b2b_accept_at_last", OUT_W'(acc1 - acc0), OUT_W'(6));
        idle(10);
        drain();
        check("b2b_beat_cycles", OUT_W'(last_hs_cyc - acc0), OUT_W'(30));

        // Random back-pressure with a mix of configurations
        rand_ready = 1'b1;
        send(64'h500, REP_NONE, 6'd0, 24, 4, 1'b1, acc0);
        send(64'h600, REP_X2, 6'd7, 7, 2, 1'b1, acc0);
        send(64'h700, 2'd3, 6'd30, 24, 1, 1'b1, acc0);
        send(64'h800, REP_X4, 6'd3, 3, 1, 1'b1, acc0);
        send(64'h900, REP_NONE, 6'd6, 6, 4, 1'b1, acc0);
        idle(1);
        drain();
        @(negedge clk);
        rand_ready = 1'b0;
        @(negedge clk);

        // Reset pulse while beat 3 of a 6-beat word is presented
        hs0 = hs_cnt;
        send(64'h300, REP_NONE, 6'd24, 24, 4, 1'b1, acc0);
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
        acc1 = 0;
        while (hs_cnt < hs0 + 2 && acc1 < 50) begin
            @(negedge clk);
            #2;
            acc1++;
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_tvalid", OUT_W'(bus.m_axis_tvalid), '0);
        check("rst_mid_tdata", bus.m_axis_tdata, '0);
        check("rst_mid_s_tready", OUT_W'(bus.s_axis_tready), OUT_W'(1'b1));
        send(64'h400, REP_NONE, 6'd8, 8, 4, 1'b1, acc0);
        idle(3);
        drain();
        check("idle_tvalid", OUT_W'(bus.m_axis_tvalid), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
